// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate L1 data cache controller.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module l1_dcache_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cache_req,
  input  logic              cache_rw,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic [DATA_W-1:0] cache_wdata,
  output logic              cache_ready,
  output logic [DATA_W-1:0] cache_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
);

  localparam int LINES = 2 ** INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MEM_RD, MEM_WR, RESP
  } state_t;

  state_t              state_q, state_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-3:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                hit_q, hit_d;
  logic                mem_req_q, mem_req_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [LINES-1:0]    valid_q, valid_d;

  logic [DATA_W-1:0]   data_arr [LINES];
  logic [TAG_W-1:0]    tag_arr  [LINES];
  logic                arr_we;
  logic [DATA_W-1:0]   arr_data;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic                  unused_addr_lsb;

  // Byte offset never reaches the word-organised arrays.
  assign unused_addr_lsb = ^cache_addr[1:0];

  assign idx = addr_q[INDEX_BITS-1:0];
  assign tag = addr_q[ADDR_W-3:INDEX_BITS];
  assign hit = valid_q[idx] && (tag_arr[idx] == tag);

  assign cache_ready = (state_q == RESP);
  assign cache_data  = rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_req_q & rw_q;
  assign mem_addr    = {addr_q, 2'b00};
  assign mem_wdata   = wdata_q;

  // Next-state, request latch, fill and memory-port control.
  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hit_d     = hit_q;
    mem_req_d = mem_req_q;
    rdata_d   = rdata_q;
    valid_d   = valid_q;
    arr_we    = 1'b0;
    arr_data  = mem_rdata;
    unique case (state_q)
      IDLE: begin
        if (cache_req) begin
          rw_d    = cache_rw;
          addr_d  = cache_addr[ADDR_W-1:2];
          wdata_d = cache_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d = hit;
        if (rw_q) begin
          mem_req_d = 1'b1;
          state_d   = MEM_WR;
        end else if (hit) begin
          rdata_d = data_arr[idx];
          state_d = RESP;
        end else begin
          mem_req_d = 1'b1;
          state_d   = MEM_RD;
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          arr_we       = 1'b1;
          arr_data     = mem_rdata;
          valid_d[idx] = 1'b1;
          rdata_d      = mem_rdata;
          mem_req_d    = 1'b0;
          state_d      = RESP;
        end
      end
      MEM_WR: begin
        if (mem_ack) begin
          arr_we    = hit_q;
          arr_data  = wdata_q;
          mem_req_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state; valid bits and outputs clear on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      hit_q     <= 1'b0;
      mem_req_q <= 1'b0;
      rdata_q   <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      hit_q     <= hit_d;
      mem_req_q <= mem_req_d;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
    end
  end

  // Tag/data storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_arr[idx] <= arr_data;
      tag_arr[idx]  <= tag;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [31:0] miss_q, miss_d;

  // Count every lookup outcome, reads and writes alike.
  always_comb begin
    hits_d = hits_q;
    miss_d = miss_q;
    if (state_q == LOOKUP) begin
      if (hit) hits_d = hits_q + 32'd1;
      else     miss_d = miss_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hits_q <= '0;
      miss_q <= '0;
    end else begin
      hits_q <= hits_d;
      miss_q <= miss_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = miss_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule
